multicycle_mem_responder: RTL and testbench

Unified instruction/data memory responder on the memory side of the multicycle RISC-V core. It accepts MemRead/MemWrite requests from the FSM controller, waits a programmable access latency, and performs byte/half/word little-endian accesses. It returns load-extended read data with a one-cycle MemReady pulse, and flags misaligned or illegal accesses.

---
 rtl/multicycle_mem_responder.sv | 147 ++++++++++++++
 tb/tb_multicycle_mem_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_mem_responder.sv
// Unified instruction/data memory responder for the multicycle RISC-V core.
// Accepts one request at a time, waits LATENCY cycles, then completes with MemReady.
module multicycle_mem_responder #(
    parameter int    ADDR_WIDTH = 10,
    parameter int    LATENCY    = 1,
    parameter string INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic [2:0]  Funct3,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        MemBusy,
    output logic        MemFault
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  accept, complete;
    logic                  rd_q, wr_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [2:0]            funct3_q;

    logic [31:0]           mem [DEPTH];
    logic [31:0]           word;
    logic [7:0]            byte_v;
    logic [15:0]           half_v;
    logic [31:0]           load_v;
    logic [31:0]           merged;
    logic                  f3_legal, misaligned, fault;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        complete = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (MemRead || MemWrite) begin
                    accept  = 1'b1;
                    cnt_d   = 4'(LATENCY);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    complete = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Legality of the captured request; both request lines high is always a fault.
    always_comb begin
        f3_legal   = 1'b0;
        misaligned = 1'b0;
        case (funct3_q)
            3'b000:         f3_legal = 1'b1;
            3'b001:         f3_legal = 1'b1;
            3'b010:         f3_legal = 1'b1;
            3'b100, 3'b101: f3_legal = rd_q;
            default:        f3_legal = 1'b0;
        endcase
        case (funct3_q)
            3'b001, 3'b101: misaligned = addr_q[0];
            3'b010:         misaligned = |addr_q[1:0];
            default:        misaligned = 1'b0;
        endcase
        fault = (rd_q && wr_q) || !f3_legal || misaligned;
    end

    always_comb begin
        word   = mem[addr_q[ADDR_WIDTH+1:2]];
        byte_v = word[{addr_q[1:0], 3'b000} +: 8];
        half_v = addr_q[1] ? word[31:16] : word[15:0];
        case (funct3_q)
            3'b000:  load_v = {{24{byte_v[7]}}, byte_v};
            3'b001:  load_v = {{16{half_v[15]}}, half_v};
            3'b100:  load_v = {24'd0, byte_v};
            3'b101:  load_v = {16'd0, half_v};
            default: load_v = word;
        endcase
        merged = word;
        case (funct3_q)
            3'b000: merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            3'b001: begin
                if (addr_q[1]) merged[31:16] = wdata_q[15:0];
                else           merged[15:0]  = wdata_q[15:0];
            end
            3'b010:  merged = wdata_q;
            default: merged = word;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            funct3_q <= 3'd0;
            ReadData <= 32'd0;
            MemReady <= 1'b0;
            MemBusy  <= 1'b0;
            MemFault <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            MemReady <= complete;
            MemFault <= complete && fault;
            MemBusy  <= (state_d == S_WAIT);
            if (accept) begin
                rd_q     <= MemRead;
                wr_q     <= MemWrite;
                addr_q   <= Addr[ADDR_WIDTH+1:0];
                wdata_q  <= WriteData;
                funct3_q <= Funct3;
            end
            if (complete && rd_q && !fault) ReadData <= load_v;
        end
    end

    // NOTE: the array has no reset; a reset mid-access drops state_q to IDLE, so the write never fires.
    always_ff @(posedge clk) begin
        if (complete && wr_q && !fault) mem[addr_q[ADDR_WIDTH+1:2]] <= merged;
    end

endmodule

// File: tb/tb_multicycle_mem_responder.sv
// Directed self-checking bench: three responders at LATENCY 1, 3 and 4.
// Inputs change #1 after a rising edge (or on a falling edge); outputs are sampled on falling edges.
module tb_multicycle_mem_responder;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic        clk;
    logic        rst_n_v   [3];
    logic        mem_read  [3];
    logic        mem_write [3];
    logic [31:0] addr      [3];
    logic [31:0] wdata     [3];
    logic [2:0]  f3        [3];
    logic [31:0] rdata     [3];
    logic        ready     [3];
    logic        busy      [3];
    logic        fault     [3];

    int checks = 0;
    int errors = 0;

    multicycle_mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_lat1 (
        .clk(clk), .reset(rst_n_v[0]), .MemRead(mem_read[0]), .MemWrite(mem_write[0]),
        .Addr(addr[0]), .WriteData(wdata[0]), .Funct3(f3[0]), .ReadData(rdata[0]),
        .MemReady(ready[0]), .MemBusy(busy[0]), .MemFault(fault[0])
    );
    multicycle_mem_responder #(.ADDR_WIDTH(10), .LATENCY(3)) u_lat3 (
        .clk(clk), .reset(rst_n_v[1]), .MemRead(mem_read[1]), .MemWrite(mem_write[1]),
        .Addr(addr[1]), .WriteData(wdata[1]), .Funct3(f3[1]), .ReadData(rdata[1]),
        .MemReady(ready[1]), .MemBusy(busy[1]), .MemFault(fault[1])
    );
    multicycle_mem_responder #(.ADDR_WIDTH(10), .LATENCY(4)) u_lat4 (
        .clk(clk), .reset(rst_n_v[2]), .MemRead(mem_read[2]), .MemWrite(mem_write[2]),
        .Addr(addr[2]), .WriteData(wdata[2]), .Funct3(f3[2]), .ReadData(rdata[2]),
        .MemReady(ready[2]), .MemBusy(busy[2]), .MemFault(fault[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for MemReady, counting falling edges seen and how many had MemBusy high.
    task automatic wait_ready(input int i, output int n, output int nb);
        n  = 0;
        nb = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy[i]) nb++;
        end while (!ready[i] && n < 40);
    endtask

    // One request: drive, let the next edge sample it, then check timing, fault and data.
    task automatic access(input int i, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] f, input int lat,
                          input logic exp_fault, input logic chk_data,
                          input logic [31:0] exp_data, input string tag);
        int n, nb;
        mem_read[i]  = rd;
        mem_write[i] = wr;
        addr[i]      = a;
        wdata[i]     = d;
        f3[i]        = f;
        @(posedge clk);
        #1;
        mem_read[i]  = 1'b0;
        mem_write[i] = 1'b0;
        wait_ready(i, n, nb);
        check({tag, "_lat"}, n, lat + 1);
        check({tag, "_busy"}, nb, lat);
        check({tag, "_fault"}, {31'd0, fault[i]}, {31'd0, exp_fault});
        if (chk_data) check({tag, "_data"}, rdata[i], exp_data);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, nb;
        for (int i = 0; i < 3; i++) begin
            rst_n_v[i]   = 1'b0;
            mem_read[i]  = 1'b0;
            mem_write[i] = 1'b0;
            addr[i]      = 32'd0;
            wdata[i]     = 32'd0;
            f3[i]        = F_W;
        end

        // Reset held with a read pending on the input.
        mem_read[0] = 1'b1;
        addr[0]     = 32'h10;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rdata", rdata[0], 32'd0);
        check("rst_ready", {31'd0, ready[0]}, 32'd0);
        check("rst_busy", {31'd0, busy[0]}, 32'd0);
        check("rst_fault", {31'd0, fault[0]}, 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) rst_n_v[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rel_busy", {31'd0, busy[0]}, 32'd1);
        check("rel_ready_early", {31'd0, ready[0]}, 32'd0);
        @(negedge clk);
        check("rel_ready", {31'd0, ready[0]}, 32'd1);
        mem_read[0] = 1'b0;
        @(posedge clk);
        #1;
        check("ready_clr", {31'd0, ready[0]}, 32'd0);

        // LATENCY 1: store/load, byte merge, extensions, faults.
        access(0, 0, 1, 32'h10, 32'hDEADBEEF, F_W,  1, 0, 0, 32'd0,        "sw10");
        access(0, 1, 0, 32'h10, 32'd0,        F_W,  1, 0, 1, 32'hDEADBEEF, "lw10");
        access(0, 0, 1, 32'h11, 32'h00000080, F_B,  1, 0, 1, 32'hDEADBEEF, "sb11");
        access(0, 1, 0, 32'h10, 32'd0,        F_W,  1, 0, 1, 32'hDEAD80EF, "lw10_m");
        access(0, 1, 0, 32'h11, 32'd0,        F_B,  1, 0, 1, 32'hFFFFFF80, "lb11");
        access(0, 1, 0, 32'h11, 32'd0,        F_BU, 1, 0, 1, 32'h00000080, "lbu11");
        access(0, 1, 0, 32'h12, 32'd0,        F_H,  1, 0, 1, 32'hFFFFDEAD, "lh12");
        access(0, 1, 0, 32'h12, 32'd0,        F_HU, 1, 0, 1, 32'h0000DEAD, "lhu12");
        access(0, 1, 0, 32'h12, 32'd0,        F_W,  1, 1, 1, 32'h0000DEAD, "lw12_flt");
        access(0, 0, 1, 32'h13, 32'h0000FFFF, F_H,  1, 1, 1, 32'h0000DEAD, "sh13_flt");
        access(0, 1, 0, 32'h10, 32'd0,        F_W,  1, 0, 1, 32'hDEAD80EF, "lw10_after");
        access(0, 1, 1, 32'h10, 32'h11111111, F_W,  1, 1, 1, 32'hDEAD80EF, "both_flt");
        access(0, 1, 0, 32'h10, 32'd0,        3'b011, 1, 1, 1, 32'hDEAD80EF, "ld_f3_flt");
        access(0, 0, 1, 32'h10, 32'h22222222, F_BU, 1, 1, 1, 32'hDEAD80EF, "st_f3_flt");
        access(0, 0, 1, 32'h12, 32'h0000BEEF, F_H,  1, 0, 0, 32'd0,        "sh12");
        access(0, 1, 0, 32'h10, 32'd0,        F_W,  1, 0, 1, 32'hBEEF80EF, "lw10_sh");
        access(0, 1, 0, 32'h1010, 32'd0,      F_W,  1, 0, 1, 32'hBEEF80EF, "alias");

        // LATENCY 3: busy span, ignored write during WAIT, back-to-back completion.
        access(1, 0, 1, 32'h40, 32'hCAFEF00D, F_W, 3, 0, 0, 32'd0,        "l3_sw40");
        access(1, 1, 0, 32'h40, 32'd0,        F_W, 3, 0, 1, 32'hCAFEF00D, "l3_lw40");
        mem_read[1] = 1'b1;
        addr[1]     = 32'h40;
        f3[1]       = F_W;
        @(posedge clk);
        #1;
        mem_read[1]  = 1'b0;
        mem_write[1] = 1'b1;
        wdata[1]     = 32'h0BADBAD0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        mem_write[1] = 1'b0;
        wait_ready(1, n, nb);
        check("l3_tog_lat", n, 32'd2);
        check("l3_tog_data", rdata[1], 32'hCAFEF00D);
        @(posedge clk);
        #1;
        access(1, 1, 0, 32'h40, 32'd0, F_W, 3, 0, 1, 32'hCAFEF00D, "l3_tog_arr");

        mem_read[1] = 1'b1;
        addr[1]     = 32'h40;
        @(posedge clk);
        #1;
        wait_ready(1, n, nb);
        check("b2b_first", n, 32'd4);
        wait_ready(1, n, nb);
        mem_read[1] = 1'b0;
        check("b2b_gap", n, 32'd4);
        check("b2b_busy", nb, 32'd3);
        @(posedge clk);
        #1;

        // LATENCY 4: reset mid-WAIT aborts the store.
        access(2, 0, 1, 32'h20, 32'hA5A5A5A5, F_W, 4, 0, 0, 32'd0,        "l4_sw20");
        access(2, 1, 0, 32'h20, 32'd0,        F_W, 4, 0, 1, 32'hA5A5A5A5, "l4_lw20");
        mem_write[2] = 1'b1;
        addr[2]      = 32'h20;
        wdata[2]     = 32'h12345678;
        @(posedge clk);
        #1;
        mem_write[2] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("l4_busy_pre", {31'd0, busy[2]}, 32'd1);
        rst_n_v[2] = 1'b0;
        #1;
        check("l4_rst_rdata", rdata[2], 32'd0);
        check("l4_rst_busy", {31'd0, busy[2]}, 32'd0);
        check("l4_rst_ready", {31'd0, ready[2]}, 32'd0);
        check("l4_rst_fault", {31'd0, fault[2]}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n_v[2] = 1'b1;
        @(posedge clk);
        #1;
        access(2, 1, 0, 32'h20, 32'd0, F_W, 4, 0, 1, 32'hA5A5A5A5, "l4_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
